// File: rtl/decoder_seq_ctrl_if.sv
// Handshake and data bundle between the sequence controller, its x/y streams and the LSTM cell.
// The slave modport is the controller's view; the master modport is the surrounding environment.
interface decoder_seq_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INPUT_SIZE  = 10,
    parameter int HIDDEN_SIZE = 10
);
    logic                         start;
    logic                         x_valid;
    logic                         x_ready;
    logic signed [DATA_WIDTH-1:0] x_data      [INPUT_SIZE];
    logic                         cell_start;
    logic                         cell_done;
    logic signed [DATA_WIDTH-1:0] cell_x      [INPUT_SIZE];
    logic signed [DATA_WIDTH-1:0] cell_h_prev [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] cell_c_prev [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] cell_h_out  [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] cell_c_out  [HIDDEN_SIZE];
    logic                         y_valid;
    logic                         y_ready;
    logic signed [DATA_WIDTH-1:0] y_data      [HIDDEN_SIZE];
    logic                         y_last;
    logic                         busy;
    logic                         done;

    modport master (
        output start, x_valid, x_data, cell_done, cell_h_out, cell_c_out, y_ready,
        input  x_ready, cell_start, cell_x, cell_h_prev, cell_c_prev,
               y_valid, y_data, y_last, busy, done
    );

    modport slave (
        input  start, x_valid, x_data, cell_done, cell_h_out, cell_c_out, y_ready,
        output x_ready, cell_start, cell_x, cell_h_prev, cell_c_prev,
               y_valid, y_data, y_last, busy, done
    );
endinterface

// File: rtl/decoder_seq_ctrl.sv
// Sequences one LSTM cell over SEQ_LEN timesteps: takes x_t, runs the cell, emits h_t,
// and carries h/c forward between steps. Data words are only moved, never computed on.
module decoder_seq_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int FRACT_WIDTH = 24,
    parameter int INPUT_SIZE  = 10,
    parameter int HIDDEN_SIZE = 10,
    parameter int SEQ_LEN     = 8
) (
    input  logic              clk,
    input  logic              rst,
    decoder_seq_ctrl_if.slave bus
);
    localparam int             T_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [T_W-1:0] T_LAST = T_W'(SEQ_LEN - 1);

    if (SEQ_LEN < 1 || SEQ_LEN > 256 || FRACT_WIDTH >= DATA_WIDTH) begin : g_cfg_check
        $error("decoder_seq_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_X    = 3'd1,
        RUN       = 3'd2,
        WAIT_CELL = 3'd3,
        EMIT      = 3'd4,
        FINISH    = 3'd5
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [T_W-1:0]               t;
    logic                         last_step;
    logic signed [DATA_WIDTH-1:0] h        [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] c        [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] y_data_r [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] cell_x_r [INPUT_SIZE];

    assign last_step = (t == T_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.start)     state_nxt = WAIT_X;
            WAIT_X:    if (bus.x_valid)   state_nxt = RUN;
            RUN:                          state_nxt = WAIT_CELL;
            WAIT_CELL: if (bus.cell_done) state_nxt = EMIT;
            EMIT:      if (bus.y_ready)   state_nxt = last_step ? FINISH : WAIT_X;
            FINISH:                       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // h/c survive into IDLE so the final recurrent state stays observable until the next start
    always_ff @(posedge clk) begin
        if (!rst) begin
            t <= '0;
            for (int i = 0; i < HIDDEN_SIZE; i++) begin
                h[i]        <= '0;
                c[i]        <= '0;
                y_data_r[i] <= '0;
            end
            for (int i = 0; i < INPUT_SIZE; i++) begin
                cell_x_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        t <= '0;
                        for (int i = 0; i < HIDDEN_SIZE; i++) begin
                            h[i] <= '0;
                            c[i] <= '0;
                        end
                    end
                end
                WAIT_X: begin
                    if (bus.x_valid) begin
                        cell_x_r <= bus.x_data;
                    end
                end
                WAIT_CELL: begin
                    if (bus.cell_done) begin
                        h        <= bus.cell_h_out;
                        c        <= bus.cell_c_out;
                        y_data_r <= bus.cell_h_out;
                    end
                end
                EMIT: begin
                    if (bus.y_ready && !last_step) begin
                        t <= t + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.x_ready     = (state == WAIT_X);
    assign bus.cell_start  = (state == RUN);
    assign bus.y_valid     = (state == EMIT);
    assign bus.y_last      = (state == EMIT) && last_step;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == FINISH);
    assign bus.cell_x      = cell_x_r;
    assign bus.cell_h_prev = h;
    assign bus.cell_c_prev = c;
    assign bus.y_data      = y_data_r;
endmodule

// File: doc/decoder_seq_ctrl.md
DECODER_SEQ_CTRL -- requirements
Module: decoder_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 32, signed fixed-point word width.
REQ-002 Parameter FRACT_WIDTH, 24, fraction bits (Q8.24); the block does no arithmetic on data words.
REQ-003 Parameter INPUT_SIZE, 10, elements per input vector x.
REQ-004 Parameter HIDDEN_SIZE, 10, elements per hidden/cell vector.
REQ-005 Parameter SEQ_LEN, 8, timesteps per sequence; the block SHALL support values from 1 to 256.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  one-cycle request to begin a sequence.
REQ-009 x_valid  in  1  x_data holds a valid timestep input.
REQ-010 x_ready  out  1  block accepts x_data this cycle.
REQ-011 x_data  in  INPUT_SIZE x DATA_WIDTH  signed timestep input vector.
REQ-012 cell_start  out  1  one-cycle start pulse to the LSTM cell.
REQ-013 cell_done  in  1  cell has finished; cell_h_out and cell_c_out are valid.
REQ-014 cell_x  out  INPUT_SIZE x DATA_WIDTH  x_t driven to the cell.
REQ-015 cell_h_prev, cell_c_prev  out  HIDDEN_SIZE x DATA_WIDTH each  recurrent state driven to the cell.
REQ-016 cell_h_out, cell_c_out  in  HIDDEN_SIZE x DATA_WIDTH each  cell results.
REQ-017 y_valid  out  1; y_ready  in  1; y_data  out  HIDDEN_SIZE x DATA_WIDTH; y_last  out  1 — output stream of per-timestep h vectors.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse at end of sequence.

Function
REQ-020 The block SHALL implement the states IDLE, WAIT_X, RUN, WAIT_CELL, EMIT and FINISH.
REQ-021 IDLE: when start=1, the block SHALL clear the h and c registers to 0, set the timestep counter t to 0, and go to WAIT_X.
REQ-022 In any state other than IDLE, the block SHALL ignore start.
REQ-023 WAIT_X: x_ready SHALL be 1 only in this state.
REQ-024 WAIT_X: when x_valid=1, the block SHALL latch x_data into the cell_x register and go to RUN.
REQ-025 RUN: cell_start SHALL be 1 for exactly one cycle, after which the block SHALL go to WAIT_CELL.
REQ-026 cell_x, cell_h_prev and cell_c_prev SHALL be registered values, held constant from RUN until cell_done is seen.
REQ-027 WAIT_CELL: when cell_done=1, the block SHALL copy cell_h_out into the h register and into y_data, copy cell_c_out into the c register, and go to EMIT.
REQ-028 cell_done SHALL be ignored in every state other than WAIT_CELL.
REQ-029 EMIT: y_valid SHALL be 1, and y_last SHALL equal (t == SEQ_LEN-1).
REQ-030 EMIT: y_data and y_last SHALL stay stable until y_ready=1.
REQ-031 EMIT with y_ready=1: if y_last=1 the block SHALL go to FINISH; otherwise it SHALL increment t and go to WAIT_X.
REQ-032 FINISH: done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-033 The h and c registers SHALL keep their final values in IDLE.
REQ-034 The h and c registers SHALL be cleared only on the next accepted start or on reset.
REQ-035 Minimum timestep latency, from x accept to y_valid, SHALL be 2 + Lcell cycles, where Lcell is the number of cycles from cell_start to cell_done.
REQ-036 If x_valid=1 and cell_done=1 arrive in the same cycle, the block SHALL act only on the signal that belongs to the current state.
REQ-037 For SEQ_LEN=1, the first EMIT SHALL assert y_last=1.

Reset
REQ-038 With rst=0 at a rising edge, the block SHALL go to IDLE, clear t, h, c, cell_x and y_data to 0, and drive x_ready, cell_start, y_valid, y_last, busy and done to 0.
REQ-039 Reset SHALL take priority over every other input, including a reset in the middle of a sequence.
REQ-040 After a mid-sequence reset, no further cell_start, y_valid or done SHALL be produced until a new start.

Verification
REQ-041 Basic sequence: SEQ_LEN=3, a cell model with Lcell=5 returning h_out=h_prev+x[0] and c_out=c_prev+1, x[0]=32'h01000000 every step -> y_data[0]=1.0, 2.0, 3.0 (Q8.24); y_last only on the third output; done one cycle after the third y handshake; c[0]=32'h00000003.
REQ-042 Zero-state check: at the first cell_start, cell_h_prev and cell_c_prev SHALL be all 32'h00000000, and x from the first timestep vector (for example x[0]=32'hfff5f212) SHALL appear on cell_x[0].
REQ-043 Backpressure: hold y_ready=0 for 10 cycles in EMIT -> y_valid stays 1, y_data stays unchanged, and no new cell_start occurs.
REQ-044 Handshake robustness: x_valid held low for 7 cycles in WAIT_X -> cell_start stays 0; a spurious cell_done in WAIT_X is ignored; start pulses while busy=1 are ignored.
REQ-045 Mid-sequence reset: rst=0 for one cycle during WAIT_CELL -> the next cycle shows busy=0 and all outputs 0; a later start runs a full SEQ_LEN sequence from zero state.
REQ-046 SEQ_LEN=1 -> exactly one output with y_last=1, followed by a done pulse.
